sha_io_responder: RTL



---
 rtl/sha_io_pkg.sv | 11 +
 rtl/sha_digest_serializer.sv | 42 ++++
 rtl/sha_io_responder.sv | 73 +++++++
 3 files changed

// File: rtl/sha_io_pkg.sv
// sha_io_pkg: shared widths and FSM states for the SHA host I/O responder
package sha_io_pkg;
  localparam int IOW = 16;
  localparam int BLOCK_BITS = 512;
  localparam int DIGEST_BITS = 256;
  localparam int BLOCK_WORDS = BLOCK_BITS / IOW;
  localparam int DIGEST_WORDS = DIGEST_BITS / IOW;
  localparam int LD_W = $clog2(BLOCK_WORDS);
  localparam int RD_W = $clog2(DIGEST_WORDS);
  typedef enum logic [1:0] {IDLE, FILL, BLKWAIT} state_t;
endpackage

// File: rtl/sha_digest_serializer.sv
// sha_digest_serializer: buffers the core digest and streams it to the host MS word first
module sha_digest_serializer
  import sha_io_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init,
  input  logic                   load,
  input  logic                   fetch,
  input  logic                   ack,
  input  logic [DIGEST_BITS-1:0] dig_data,
  input  logic                   dig_valid,
  output logic [IOW-1:0]         odata,
  output logic                   fe_acc,
  output logic                   ovr_err
);
  logic [DIGEST_BITS-1:0] dbuf;
  logic [RD_W-1:0] rd_cnt;
  logic dig_avail;
  always_comb fe_acc = fetch & ~load & ~ack & dig_avail;
  always_ff @(posedge clk)
    if (rst || init) begin
      dbuf <= '0;
      rd_cnt <= '0;
      dig_avail <= 1'b0;
      odata <= '0;
      ovr_err <= 1'b0;
    end else begin
      ovr_err <= dig_valid & dig_avail;
      if (fe_acc) begin
        odata <= dbuf[DIGEST_BITS-1 -: IOW];
        dbuf <= {dbuf[DIGEST_BITS-IOW-1:0], {IOW{1'b0}}};
        rd_cnt <= rd_cnt + 1'b1;
        dig_avail <= rd_cnt != RD_W'(DIGEST_WORDS - 1);
      end
      if (dig_valid) begin
        dbuf <= dig_data;
        rd_cnt <= '0;
        dig_avail <= 1'b1;
      end
    end
endmodule

// File: rtl/sha_io_responder.sv
// sha_io_responder: host-side init/load/fetch/ack responder feeding blocks to and digests from the SHA core
module sha_io_responder
  import sha_io_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init,
  input  logic                   load,
  input  logic                   fetch,
  input  logic [IOW-1:0]         idata,
  output logic                   ack,
  output logic [IOW-1:0]         odata,
  output logic                   err,
  output logic [BLOCK_BITS-1:0]  blk_data,
  output logic                   blk_valid,
  output logic                   blk_first,
  input  logic                   blk_ready,
  input  logic [DIGEST_BITS-1:0] dig_data,
  input  logic                   dig_valid
);
  state_t state, state_nxt;
  logic [LD_W-1:0] ld_cnt;
  logic [BLOCK_BITS-1:0] sreg;
  logic first_flag, ld_acc, ld_last, fe_acc, ovr_err, cfl_err;
  always_comb ld_acc = load & ~fetch & ~ack & ~blk_valid;
  always_comb ld_last = ld_acc & (ld_cnt == LD_W'(BLOCK_WORDS - 1));
  always_ff @(posedge clk) state <= (rst || init) ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ld_acc ? FILL : IDLE;
      FILL:    state_nxt = ld_last ? BLKWAIT : FILL;
      BLKWAIT: state_nxt = blk_ready ? FILL : BLKWAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    blk_valid = state == BLKWAIT;
    blk_first = blk_valid & first_flag;
    err = cfl_err | ovr_err;
  end
  always_ff @(posedge clk)
    if (rst || init) begin
      ld_cnt <= '0;
      sreg <= '0;
      blk_data <= '0;
      first_flag <= 1'b1;
      ack <= 1'b0;
      cfl_err <= 1'b0;
    end else begin
      ack <= ld_acc | fe_acc;
      cfl_err <= load & fetch;
      if (ld_acc) begin
        ld_cnt <= ld_cnt + 1'b1;
        sreg <= {sreg[BLOCK_BITS-IOW-1:0], idata};
      end
      if (ld_last) blk_data <= {sreg[BLOCK_BITS-IOW-1:0], idata};
      if (blk_valid && blk_ready) first_flag <= 1'b0;
    end
  sha_digest_serializer u_ser (
    .clk(clk),
    .rst(rst),
    .init(init),
    .load(load),
    .fetch(fetch),
    .ack(ack),
    .dig_data(dig_data),
    .dig_valid(dig_valid),
    .odata(odata),
    .fe_acc(fe_acc),
    .ovr_err(ovr_err)
  );
endmodule
